// File: rtl/ram_phrase_reader.sv
// ram_phrase_reader
//
// Sequential read master for the phrase data RAM. This RAM is single-port
// and has a one-cycle registered read. On an accepted start the block reads
// words from base_addr upward. It presents each word on a valid/ready output
// port. A sequence stops on a terminator word, after max_len words, or when
// the pointer runs off the end of the RAM.
//
// Handshake: a word transfers on a rising edge where out_valid_o && out_ready_i.
// While out_valid_o is high, out_data_o is held stable. out_valid_o is never
// withdrawn without an acceptance, except by reset.
//
// Ports
//   clock_i        system clock, rising edge
//   reset_n_i      synchronous active-low reset
//   start_i        begin a sequence (sampled only in IDLE)
//   base_addr_i    first RAM address, captured on accepted start
//   max_len_i      maximum words to emit, captured on accepted start
//   ram_address_o  RAM address
//   ram_wren_o     RAM write enable (always 0)
//   ram_data_o     RAM write data (always 0)
//   ram_q_i        RAM read data (one cycle after address)
//   out_data_o     emitted word
//   out_valid_o    out_data_o valid
//   out_ready_i    consumer ready
//   busy_o         high in every state except IDLE
//   done_o         one-cycle pulse at end of a sequence
//   overrun_o      sequence ended by reaching the end of the RAM
//   words_sent_o   words accepted in the current/last sequence
//   state_o        current FSM state (debug observation)

module ram_phrase_reader #(
    parameter int unsigned DEPTH = 328,
    parameter logic [31:0] TERM  = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [31:0] max_len_i,
    output logic [31:0] ram_address_o,
    output logic        ram_wren_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_q_i,
    output logic [31:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        overrun_o,
    output logic [31:0] words_sent_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_LATCH  = 3'd2,
        S_SEND   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state_q, state_d;
    logic [31:0] ptr_q, ptr_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] words_q, words_d;
    logic        overrun_q, overrun_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ptr_inc;

    assign ptr_inc = ptr_q + 32'd1;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            words_q   <= '0;
            overrun_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            words_q   <= words_d;
            overrun_q <= overrun_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
        end
    end

    // The address register is loaded on the transition into ISSUE. As a
    // result it shows ptr throughout ISSUE and LATCH, and it keeps the last
    // read address at all other times.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        words_d   = words_q;
        overrun_d = overrun_q;
        data_d    = data_q;
        valid_d   = valid_q;
        addr_d    = addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ptr_d     = base_addr_i;
                    rem_d     = max_len_i;
                    words_d   = '0;
                    overrun_d = 1'b0;
                    if (max_len_i == 32'd0) begin
                        state_d = S_FINISH;
                    end else if (base_addr_i >= DEPTH_W) begin
                        overrun_d = 1'b1;
                        state_d   = S_FINISH;
                    end else begin
                        addr_d  = base_addr_i;
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                state_d = S_LATCH;
            end

            S_LATCH: begin
                if (ram_q_i == TERM) begin
                    state_d = S_FINISH;
                end else begin
                    data_d  = ram_q_i;
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    words_d = words_q + 32'd1;
                    rem_d   = rem_q - 32'd1;
                    ptr_d   = ptr_inc;
                    // The length limit is checked before the end-of-RAM
                    // check, so a sequence that hits both ends cleanly.
                    if (rem_q == 32'd1) begin
                        state_d = S_FINISH;
                    end else if (ptr_inc == DEPTH_W) begin
                        overrun_d = 1'b1;
                        state_d   = S_FINISH;
                    end else begin
                        addr_d  = ptr_inc;
                        state_d = S_ISSUE;
                    end
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ram_address_o = addr_q;
    assign ram_wren_o    = 1'b0;
    assign ram_data_o    = 32'd0;
    assign out_data_o    = data_q;
    assign out_valid_o   = valid_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_FINISH);
    assign overrun_o     = overrun_q;
    assign words_sent_o  = words_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_ram_phrase_reader.sv
module tb_ram_phrase_reader;

  localparam int DEPTH = 328;

  logic        clock_i = 1'b0;
  logic        reset_n_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [31:0] max_len_i;
  logic [31:0] ram_address_o;
  logic        ram_wren_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_q_i;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        overrun_o;
  logic [31:0] words_sent_o;
  logic [2:0]  state_o;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr[$];
  logic [31:0] alog[$];

  ram_phrase_reader dut (
    .clock_i       (clock_i),
    .reset_n_i     (reset_n_i),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .max_len_i     (max_len_i),
    .ram_address_o (ram_address_o),
    .ram_wren_o    (ram_wren_o),
    .ram_data_o    (ram_data_o),
    .ram_q_i       (ram_q_i),
    .out_data_o    (out_data_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .overrun_o     (overrun_o),
    .words_sent_o  (words_sent_o),
    .state_o       (state_o)
  );

  // clock / reset block
  always #5 clock_i = ~clock_i;

  // registered-read RAM model
  always @(posedge clock_i) begin
    if (ram_address_o < 32'(DEPTH))
      ram_q_i <= mem[ram_address_o];
    else
      ram_q_i <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, ram_address_o, 32'd0);
    chk({tag, "_data"}, out_data_o, 32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun_o}, 32'd0);
    chk({tag, "_words"}, words_sent_o, 32'd0);
    chk({tag, "_wren"}, {31'd0, ram_wren_o}, 32'd0);
    chk({tag, "_wdata"}, ram_data_o, 32'd0);
  endtask

  // Reference model: walk the RAM from base and apply the stop rules directly.
  task automatic model(input logic [31:0] base, input logic [31:0] len, output logic e_ovr);
    logic [31:0] a;
    logic [31:0] n;
    exp_q.delete();
    exp_addr.delete();
    a = base;
    n = 0;
    e_ovr = 1'b0;
    while (1) begin
      if (n == len) break;
      if (a >= 32'(DEPTH)) begin
        e_ovr = 1'b1;
        break;
      end
      exp_addr.push_back(a);
      if (mem[a] == 32'd0) break;
      exp_q.push_back(mem[a]);
      n++;
      a++;
    end
  endtask

  // driver + monitor for one sequence; inputs change and outputs are sampled at negedge
  task automatic run_seq(input logic [31:0] base, input logic [31:0] len, input int hold_first,
                         input int ready_pct, input int stray_cyc, input bit check_timing);
    logic        e_ovr;
    logic [31:0] addr_before;
    logic [31:0] pend_data;
    logic [31:0] pend_addr;
    int cyc, got, hold_cnt, busy_cycles, prev_first;
    bit pending, done_seen, rdy;
    model(base, len, e_ovr);
    alog.delete();
    addr_before = ram_address_o;
    start_i = 1'b1;
    base_addr_i = base;
    max_len_i = len;
    out_ready_i = 1'b0;
    @(negedge clock_i);
    start_i = 1'b0;
    cyc = 0; got = 0; hold_cnt = 0; busy_cycles = 0; prev_first = 0;
    pending = 0; done_seen = 0;
    while (!done_seen && cyc < 2000) begin
      if (cyc == stray_cyc) begin
        start_i = 1'b1;
        base_addr_i = 32'd0;
        max_len_i = 32'd1;
      end else begin
        start_i = 1'b0;
      end
      if (busy_o) busy_cycles++;
      if (busy_o && exp_addr.size() != 0 && (alog.size() == 0 || alog[$] != ram_address_o))
        alog.push_back(ram_address_o);
      if (out_valid_o) begin
        if (!pending) begin
          if (got < exp_q.size())
            chk("word", out_data_o, exp_q[got]);
          else
            chk("extra_word", {31'd0, out_valid_o}, 32'd0);
          if (check_timing) begin
            if (got == 0) chk("first_latency", 32'(cyc), 32'd2);
            else chk("word_spacing", 32'(cyc - prev_first), 32'd3);
          end
          prev_first = cyc;
          pending = 1;
          pend_data = out_data_o;
          pend_addr = ram_address_o;
          hold_cnt = 0;
        end else begin
          chk("hold_data", out_data_o, pend_data);
          chk("hold_addr", ram_address_o, pend_addr);
        end
        if (got == 0 && hold_cnt < hold_first) rdy = 0;
        else rdy = ($urandom_range(99) < 32'(ready_pct));
        hold_cnt++;
        out_ready_i = rdy;
        if (rdy) begin
          got++;
          pending = 0;
        end
      end else begin
        if (pending) chk("valid_withdrawn", {31'd0, out_valid_o}, 32'd1);
        pending = 0;
        out_ready_i = 1'($urandom_range(1));
      end
      if (done_o) done_seen = 1;
      @(negedge clock_i);
      cyc++;
    end
    start_i = 1'b0;
    out_ready_i = 1'b0;
    chk("done_seen", {31'd0, done_seen}, 32'd1);
    chk("done_pulse", {31'd0, done_o}, 32'd0);
    chk("idle_after", {31'd0, busy_o}, 32'd0);
    chk("words_sent", words_sent_o, 32'(exp_q.size()));
    chk("words_got", 32'(got), 32'(exp_q.size()));
    chk("overrun", {31'd0, overrun_o}, {31'd0, e_ovr});
    chk("read_count", 32'(alog.size()), 32'(exp_addr.size()));
    for (int i = 0; i < alog.size() && i < exp_addr.size(); i++)
      chk("read_addr", alog[i], exp_addr[i]);
    if (exp_addr.size() == 0) begin
      chk("no_read_addr", ram_address_o, addr_before);
      chk("no_read_busy", 32'(busy_cycles), 32'd1);
    end
    if (check_timing)
      chk("busy_cycles", 32'(busy_cycles), 32'(2 * exp_addr.size() + exp_q.size() + 1));
  endtask

  initial begin
    logic [31:0] b, l;
    int guard;
    reset_n_i = 1'b0;
    start_i = 1'b0;
    base_addr_i = 32'd0;
    max_len_i = 32'd0;
    out_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'($urandom_range(32'h7E, 32'h21));
    mem[10] = 32'h48; mem[11] = 32'h6F; mem[12] = 32'h6C; mem[13] = 32'h61; mem[14] = 32'h0;

    // reset state
    repeat (2) @(negedge clock_i);
    chk_all_zero("reset");
    reset_n_i = 1'b1;
    @(negedge clock_i);

    // phrase, full rate
    run_seq(32'd10, 32'd100, 0, 100, -1, 1);
    // length limit
    run_seq(32'd10, 32'd2, 0, 100, -1, 1);
    // backpressure on first word
    run_seq(32'd10, 32'd100, 7, 100, -1, 0);
    // end of RAM
    run_seq(32'd326, 32'd10, 0, 100, -1, 1);
    // out-of-range base
    run_seq(32'd328, 32'd5, 0, 100, -1, 1);
    // zero length
    run_seq(32'd10, 32'd0, 0, 100, -1, 1);
    // start while busy is ignored
    run_seq(32'd10, 32'd100, 0, 100, 1, 1);

    // reset during SEND, with start held at the same time
    start_i = 1'b1; base_addr_i = 32'd10; max_len_i = 32'd100; out_ready_i = 1'b0;
    @(negedge clock_i);
    start_i = 1'b0;
    guard = 0;
    while (!out_valid_o && guard < 20) begin
      @(negedge clock_i);
      guard++;
    end
    chk("reach_send", {31'd0, out_valid_o}, 32'd1);
    reset_n_i = 1'b0;
    start_i = 1'b1;
    @(negedge clock_i);
    chk_all_zero("mid_reset");
    start_i = 1'b0;
    reset_n_i = 1'b1;
    @(negedge clock_i);
    chk("post_reset_idle", {31'd0, busy_o}, 32'd0);
    run_seq(32'd10, 32'd100, 0, 100, -1, 1);

    // randomized sequences
    for (int i = 0; i < DEPTH; i++)
      mem[i] = ($urandom_range(9) == 0) ? 32'd0 : $urandom | 32'h1;
    for (int t = 0; t < 30; t++) begin
      b = ($urandom_range(3) == 0) ? 32'($urandom_range(330, 318)) : 32'($urandom_range(330, 0));
      l = 32'($urandom_range(8, 0));
      run_seq(b, l, int'($urandom_range(3)), 60, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
